// File: rtl/updown_cmd_gen_if.sv
// Pushbutton-to-counter command bundle: raw buttons in, count strobe and direction out.
interface updown_cmd_gen_if;
  logic btn_up;
  logic btn_down;
  logic enable;
  logic dir;

  modport master (output btn_up, output btn_down, input enable, input dir);
  modport slave  (input btn_up, input btn_down, output enable, output dir);
endinterface

// File: rtl/updown_cmd_gen.sv
// Up/down counter command generator: synchronise and debounce two buttons, then emit
// single-cycle enable pulses with direction, auto-repeating while a single button is held.
module updown_cmd_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  updown_cmd_gen_if.slave    bus
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOCKED} state_t;

  // Index 0 = up button, index 1 = down button.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [CW-1:0] cnt [2];
  logic [1:0]    rel_c;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          enable_q, enable_nx;
  logic          dir_q, dir_nx;

  logic up_db, down_db, both_hi_c, both_lo_c, held_c, held_rel_c;

  // Two-flop synchronisers followed by per-button debounce counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {bus.btn_down, bus.btn_up};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A debounced level that is about to fall on this edge; lets release win over a due pulse.
  always_comb begin
    for (int i = 0; i < 2; i++)
      rel_c[i] = stable[i] & ~sync2[i] & (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  end

  assign up_db      = stable[0];
  assign down_db    = stable[1];
  assign both_hi_c  = up_db & down_db;
  assign both_lo_c  = ~up_db & ~down_db;
  assign held_c     = dir_q ? (up_db & ~down_db) : (down_db & ~up_db);
  assign held_rel_c = dir_q ? rel_c[0] : rel_c[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      enable_q <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      enable_q <= enable_nx;
      dir_q    <= dir_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    enable_nx = 1'b0;
    dir_nx    = dir_q;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (both_hi_c) begin
          state_nx = BLOCKED;
        end else if (up_db ^ down_db) begin
          enable_nx = 1'b1;
          dir_nx    = up_db;
          state_nx  = HOLD;
        end
      end
      HOLD: begin
        if (both_hi_c) begin
          state_nx = BLOCKED;
          timer_nx = '0;
        end else if (!held_c) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (timer == TW'(HOLD_CYCLES - 1) && !held_rel_c) begin
          enable_nx = 1'b1;
          state_nx  = REPEAT;
          timer_nx  = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      REPEAT: begin
        if (both_hi_c) begin
          state_nx = BLOCKED;
          timer_nx = '0;
        end else if (!held_c) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (timer == TW'(REPEAT_CYCLES - 1) && !held_rel_c) begin
          enable_nx = 1'b1;
          timer_nx  = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      BLOCKED: begin
        timer_nx = '0;
        if (both_lo_c) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  assign bus.enable = enable_q;
  assign bus.dir    = dir_q;

endmodule

// File: tb/tb_updown_cmd_gen.sv
// Directed bench for updown_cmd_gen: per-cycle check of enable/dir against hand-computed pulse masks.
module tb_updown_cmd_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  updown_cmd_gen_if bus ();

  updown_cmd_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (16),
    .REPEAT_CYCLES  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;
  logic exp_dir;

  // One press: button(s) raw-high for edges 1..press, low until edge total.
  // mask bit e set = enable expected high just after edge e of the segment.
  typedef struct {
    logic        up;
    logic        down;
    int          press;
    int          total;
    logic [63:0] mask;
    logic        pdir;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string nm, input logic en_exp, input logic dir_exp);
    nvec++;
    if (bus.enable !== en_exp || bus.dir !== dir_exp) begin
      nerr++;
      $display("FAIL %s @%0t: enable=%b dir=%b, expected enable=%b dir=%b",
               nm, $time, bus.enable, bus.dir, en_exp, dir_exp);
    end
  endtask

  task automatic cyc(input logic up, input logic dn, input logic en_exp, input logic dir_exp,
                     input string nm);
    bus.btn_up   = up;
    bus.btn_down = dn;
    @(posedge clk);
    #1;
    check(nm, en_exp, dir_exp);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b1, 3,  20, 64'h0,                   1'b0}; // 3-cycle glitch rejected
    vt[1] = '{1'b1, 1'b0, 4,  25, 64'h80,                  1'b1}; // 4-cycle press accepted
    vt[2] = '{1'b1, 1'b0, 10, 30, 64'h80,                  1'b1}; // single up press
    vt[3] = '{1'b0, 1'b1, 37, 60, 64'h0000_0088_8880_0080, 1'b0}; // repeat; edge-43 pulse lost to release
    vt[4] = '{1'b1, 1'b0, 10, 25, 64'h80,                  1'b1}; // direction switch: up
    vt[5] = '{1'b0, 1'b1, 10, 25, 64'h80,                  1'b0}; // then down

    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    exp_dir      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    for (int v = 0; v < 6; v++) begin
      for (int e = 1; e <= vt[v].total; e++) begin
        logic en;
        en = vt[v].mask[e];
        if (en) exp_dir = vt[v].pdir;
        cyc(vt[v].up && (e <= vt[v].press), vt[v].down && (e <= vt[v].press), en, exp_dir,
            $sformatf("vec%0d_edge%0d", v, e));
      end
    end

    // Conflict: up held, down joins at edge 12 -> only the edge-7 pulse.
    for (int e = 1; e <= 40; e++) begin
      if (e == 7) exp_dir = 1'b1;
      cyc(1'b1, e >= 12, e == 7, exp_dir, $sformatf("conflict_edge%0d", e));
    end
    for (int e = 1; e <= 20; e++) cyc(1'b0, 1'b0, 1'b0, exp_dir, "conflict_release");
    for (int e = 1; e <= 25; e++)
      cyc(e <= 10, 1'b0, e == 7, exp_dir, $sformatf("conflict_repress_edge%0d", e));

    // Switch to down so the pulse before reset visibly sets dir=1.
    for (int e = 1; e <= 25; e++) begin
      if (e == 7) exp_dir = 1'b0;
      cyc(1'b0, e <= 10, e == 7, exp_dir, $sformatf("pre_reset_down_edge%0d", e));
    end

    // Reset mid-press: asynchronous clear right after a pulse, then a fresh first pulse.
    for (int e = 1; e <= 7; e++) begin
      if (e == 7) exp_dir = 1'b1;
      cyc(1'b1, 1'b0, e == 7, exp_dir, $sformatf("pre_reset_up_edge%0d", e));
    end
    #2 rst = 1'b1;
    #1;
    check("async_reset", 1'b0, 1'b0);
    exp_dir = 1'b0;
    @(posedge clk);
    #1;
    check("reset_held", 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 7) exp_dir = 1'b1;
      cyc(1'b1, 1'b0, e == 7, exp_dir, $sformatf("post_reset_edge%0d", e));
    end
    for (int e = 1; e <= 20; e++) cyc(1'b0, 1'b0, 1'b0, exp_dir, "post_reset_release");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
